// File: rtl/ysyx_24090012_mem_pkg.sv
// ysyx_24090012_mem_pkg: FSM encoding and constants shared by the LSU SRAM model
package ysyx_24090012_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/ysyx_24090012_lfsr8.sv
// ysyx_24090012_lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping every cycle
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset, loads seed
//   seed in  reset value, must be non-zero
//   out  out current LFSR state
module ysyx_24090012_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] out
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) out <= seed;
    else out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
endmodule

// File: rtl/ysyx_24090012_lsu_sram.sv
// ysyx_24090012_lsu_sram: word-addressed SRAM slave with delayed valid/ready handshakes
//   clk, rst (async active-low)
//   sram_addr/arvalid/arready/sram_wen/sram_wdata/sram_wmask: request channel
//   rvalid/rready/sram_rdata: response channel
//   access_err: sticky out-of-range flag
module ysyx_24090012_lsu_sram import ysyx_24090012_mem_pkg::*; #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter bit          RAND_DELAY = 1'b1,
  parameter int          AR_DELAY   = 0,
  parameter int          R_DELAY    = 1,
  parameter int          DELAY_BITS = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sram_addr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        sram_wen,
  input  logic [31:0] sram_wdata,
  input  logic [3:0]  sram_wmask,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] sram_rdata,
  output logic        access_err
);
  state_t state, state_nx;
  logic [7:0] ar_cnt, r_cnt, lfsr, ar_load, r_load;
  logic [31:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic in_range;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic unused;

  ysyx_24090012_lfsr8 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .out(lfsr));

  assign off = sram_addr - BASE_ADDR;
  // Offsets below BASE_ADDR wrap to huge values, so one shift test covers both bounds.
  assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx = off[DEPTH_LOG2+1:2];
  assign ar_load = RAND_DELAY ? 8'(lfsr[DELAY_BITS-1:0]) : 8'(AR_DELAY);
  // Holds R delay minus one: zero means the response follows the accept edge directly.
  assign r_load = RAND_DELAY ? 8'(lfsr[DELAY_BITS+3:4]) : 8'(R_DELAY - 1);
  assign unused = ^{off[1:0], lfsr};

  always_comb begin
    arready = rst && state == IDLE && arvalid && ar_cnt == 8'd0;
    rvalid = state == RESP;
    state_nx = state == IDLE ? (arready ? (r_load == 8'd0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (r_cnt <= 8'd1 ? RESP : WAIT)
             : (rready ? IDLE : RESP);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ar_cnt <= '0;
      r_cnt <= '0;
      sram_rdata <= '0;
      access_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (rvalid && rready) ar_cnt <= ar_load;
      else if (state == IDLE && arvalid && ar_cnt != 8'd0) ar_cnt <= ar_cnt - 8'd1;
      if (arready) r_cnt <= r_load;
      else if (state == WAIT) r_cnt <= r_cnt - 8'd1;
      if (arready) sram_rdata <= sram_wen ? 32'h0 : in_range ? mem[idx] : OOR_RDATA;
      if (arready && !in_range) access_err <= 1'b1;
    end

  always_ff @(posedge clk)
    if (arready && sram_wen && in_range)
      for (int i = 0; i < 4; i++)
        if (sram_wmask[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
endmodule

// File: tb/tb_ysyx_24090012_lsu_sram.sv
// tb_ysyx_24090012_lsu_sram: directed and scoreboard checks of the LSU SRAM model
module tb_ysyx_24090012_lsu_sram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst, arvalid, arready, wen, rvalid, rready, err;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0] wmask [3];
  int n_chk = 0, n_err = 0;
  logic pend = 1'b0, mon = 1'b0;
  logic [31:0] rd, model [16];
  int arl, rl;

  for (genvar g = 0; g < 3; g++) begin : gd
    ysyx_24090012_lsu_sram #(
      .RAND_DELAY(g == 2), .AR_DELAY(g == 1 ? 3 : 0), .R_DELAY(g == 1 ? 2 : 1)
    ) dut (
      .clk(clk), .rst(rst[g]), .sram_addr(addr[g]), .arvalid(arvalid[g]),
      .arready(arready[g]), .sram_wen(wen[g]), .sram_wdata(wdata[g]),
      .sram_wmask(wmask[g]), .rvalid(rvalid[g]), .rready(rready[g]),
      .sram_rdata(rdata[g]), .access_err(err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ar(input int d, output int n);
    n = 0;
    #1;
    while (!arready[d] && n < 50) begin @(negedge clk); #1; n++; end
    if (!arready[d]) chk("ar_timeout", 32'(arready[d]), 1);
  endtask

  task automatic wait_rv(input int d, output int n);
    n = 1;
    #1;
    while (!rvalid[d] && n < 50) begin @(negedge clk); #1; n++; end
    if (!rvalid[d]) chk("r_timeout", 32'(rvalid[d]), 1);
  endtask

  task automatic req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input int hold,
                     output logic [31:0] data, output int al, output int r);
    addr[d] = a; wdata[d] = wd; wmask[d] = m; wen[d] = w; arvalid[d] = 1'b1;
    wait_ar(d, al);
    @(posedge clk);
    @(negedge clk);
    arvalid[d] = 1'b0; wen[d] = 1'b0;
    wait_rv(d, r);
    data = rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("hold_rvalid", 32'(rvalid[d]), 1);
      chk("hold_rdata", rdata[d], data);
    end
    rready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready[d] = 1'b0;
  endtask

  always @(posedge clk)
    pend <= !rst[2] ? 1'b0 : (arvalid[2] && arready[2]) ? 1'b1 : (rvalid[2] && rready[2]) ? 1'b0 : pend;

  always @(negedge clk)
    if (mon && rvalid[2]) chk("rv_no_ar", 32'(pend), 1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = '0; arvalid = 3'b011; wen = '0; rready = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; wmask[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_arready", 32'(arready[i]), 0);
      chk("rst_rvalid", 32'(rvalid[i]), 0);
      chk("rst_rdata", rdata[i], 0);
      chk("rst_err", 32'(err[i]), 0);
    end
    arvalid = '0; rst = '1;
    // fixed AR 0 / R 1: full write then read
    req(0, 1, 32'h8000_0000, 32'h1122_3344, 4'hF, 0, rd, arl, rl);
    chk("t1_w_arlat", arl, 0); chk("t1_w_rlat", rl, 1); chk("t1_w_rdata", rd, 0);
    req(0, 0, 32'h8000_0000, 0, 0, 0, rd, arl, rl);
    chk("t1_r_arlat", arl, 0); chk("t1_r_rlat", rl, 1); chk("t1_r_rdata", rd, 32'h1122_3344);
    // byte-masked write
    req(0, 1, 32'h8000_0000, 32'hAABB_CCDD, 4'b0010, 0, rd, arl, rl);
    req(0, 0, 32'h8000_0000, 0, 0, 0, rd, arl, rl);
    chk("t2_rdata", rd, 32'h1122_CC44);
    // out of range below and above the window
    req(0, 0, 32'h7FFF_FFFC, 0, 0, 0, rd, arl, rl);
    chk("t4_oor_rdata", rd, 32'hDEAD_BEEF); chk("t4_err", 32'(err[0]), 1);
    req(0, 1, 32'h8000_1000, 32'h5555_5555, 4'hF, 0, rd, arl, rl);
    chk("t4_oor_wdata", rd, 0); chk("t4_err_sticky", 32'(err[0]), 1);
    req(0, 0, 32'h8000_0000, 0, 0, 0, rd, arl, rl);
    chk("t4_mem_kept", rd, 32'h1122_CC44);
    req(0, 0, 32'h8000_0FFC, 0, 0, 0, rd, arl, rl);
    chk("t4_err_still", 32'(err[0]), 1);
    // fixed AR 3 / R 2 with response back-pressure
    req(1, 1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, rd, arl, rl);
    chk("t3_warm_arlat", arl, 0);
    req(1, 0, 32'h8000_0010, 0, 0, 4, rd, arl, rl);
    chk("t3_arlat", arl, 3); chk("t3_rlat", rl, 2); chk("t3_rdata", rd, 32'hCAFE_F00D);
    req(1, 1, 32'h8000_0014, 32'h0BAD_C0DE, 4'hF, 0, rd, arl, rl);
    chk("t3_b2b_arlat", arl, 3); chk("t3_b2b_rlat", rl, 2);
    req(1, 0, 32'h8000_0014, 0, 0, 0, rd, arl, rl);
    chk("t3_b2b_rdata", rd, 32'h0BAD_C0DE);
    // reset while in WAIT after a committed write
    addr[1] = 32'h8000_0020; wdata[1] = 32'h1357_9BDF; wmask[1] = 4'hF; wen[1] = 1'b1; arvalid[1] = 1'b1;
    wait_ar(1, arl);
    @(posedge clk);
    @(negedge clk);
    wen[1] = 1'b0;
    #1;
    chk("t5_wait_rvalid", 32'(rvalid[1]), 0);
    rst[1] = 1'b0;
    #1;
    chk("t5_wait_rst_arready", 32'(arready[1]), 0);
    chk("t5_wait_rst_rvalid", 32'(rvalid[1]), 0);
    @(negedge clk);
    rst[1] = 1'b1; arvalid[1] = 1'b0;
    // reset while in RESP
    arvalid[1] = 1'b1;
    wait_ar(1, arl);
    @(posedge clk);
    @(negedge clk);
    arvalid[1] = 1'b0;
    wait_rv(1, rl);
    chk("t5_resp_rdata", rdata[1], 32'h1357_9BDF);
    rst[1] = 1'b0; arvalid[1] = 1'b1;
    #1;
    chk("t5_resp_rst_rvalid", 32'(rvalid[1]), 0);
    chk("t5_resp_rst_arready", 32'(arready[1]), 0);
    @(negedge clk);
    rst[1] = 1'b1; arvalid[1] = 1'b0;
    req(1, 0, 32'h8000_0020, 0, 0, 0, rd, arl, rl);
    chk("t5_after_rlat", rl, 2); chk("t5_after_rdata", rd, 32'h1357_9BDF);
    // random delays against a scoreboard
    mon = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      req(2, 1, 32'h8000_0000 + 32'(4 * i), model[i], 4'hF, 0, rd, arl, rl);
    end
    for (int n = 0; n < 1000; n++) begin
      automatic logic w = 1'($urandom_range(0, 1));
      automatic int i = $urandom_range(0, 15);
      automatic logic [3:0] m = 4'($urandom_range(0, 15));
      automatic logic [31:0] d = $urandom;
      req(2, w, 32'h8000_0000 + 32'(4 * i), d, m, $urandom_range(0, 2), rd, arl, rl);
      chk("r6_arlat", 32'(arl <= 3), 1);
      chk("r6_rlat", 32'(rl >= 1 && rl <= 4), 1);
      if (w) begin
        for (int k = 0; k < 4; k++) if (m[k]) model[i][8*k +: 8] = d[8*k +: 8];
        chk("r6_wdata", rd, 0);
      end else chk("r6_rdata", rd, model[i]);
    end
    mon = 1'b0;
    chk("r6_err", 32'(err[2]), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
